// File: rtl/exp_pkg.sv
// Shared definitions for the exponent pipeline: op encoding, bias helper
// and the guard width used for the intermediate signed exponent arithmetic.
package exp_pkg;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } exp_op_e;

  localparam int EXP_W_DEFAULT = 8;
  // Two guard bits: one for the carry of a+b, one for the sign of a-b.
  localparam int INT_GUARD     = 2;
  localparam int INT_W_DEFAULT = EXP_W_DEFAULT + INT_GUARD;

  function automatic int default_bias(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int int_width(input int w);
    return w + INT_GUARD;
  endfunction

endpackage

// File: rtl/exp_classify.sv
// Combinational range check of a signed biased exponent: raises overflow /
// underflow and optionally clamps the emitted code to the finite range.
module exp_classify
  import exp_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEFAULT
) (
  input  logic signed [EXP_W+INT_GUARD-1:0] r,
  input  logic                              sat,
  output logic        [EXP_W-1:0]           exp,
  output logic                              ovf,
  output logic                              unf
);

  localparam int IW = int_width(EXP_W);

  // All-ones is reserved, so anything from there upwards overflows.
  localparam logic signed [IW-1:0] OVF_TH     = IW'((1 << EXP_W) - 1);
  localparam logic signed [IW-1:0] ZERO_S     = '0;
  localparam logic        [EXP_W-1:0] MAX_FIN = EXP_W'((1 << EXP_W) - 2);

  always_comb begin
    ovf = (r >= OVF_TH);
    unf = (r <= ZERO_S);
    exp = r[EXP_W-1:0];
    if (sat) begin
      if (ovf) begin
        exp = MAX_FIN;
      end else if (unf) begin
        exp = '0;
      end
    end
  end

endmodule

// File: rtl/exp_pipe_unit.sv
// Two-stage biased-exponent unit for multiply/divide with valid/ready
// flow control; stage 1 forms the raw sum/difference, stage 2 biases and classifies.
module exp_pipe_unit
  import exp_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEFAULT,
  parameter int BIAS  = default_bias(EXP_W),
  parameter bit SAT   = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [EXP_W-1:0] a,
  input  logic [EXP_W-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W-1:0] out_exp,
  output logic             out_ovf,
  output logic             out_unf
);

  localparam int IW = int_width(EXP_W);
  localparam logic signed [IW-1:0] BIAS_S = IW'(BIAS);

  exp_op_e                op_e;
  logic signed [IW-1:0]   a_ext;
  logic signed [IW-1:0]   b_ext;
  logic signed [IW-1:0]   s1_term_next;
  logic                   s1_valid_reg;
  logic signed [IW-1:0]   s1_term_reg;
  exp_op_e                s1_op_reg;
  logic signed [IW-1:0]   r_next;
  logic [EXP_W-1:0]       cls_exp;
  logic                   cls_ovf;
  logic                   cls_unf;
  logic                   out_valid_reg;
  logic [EXP_W-1:0]       out_exp_reg;
  logic                   out_ovf_reg;
  logic                   out_unf_reg;
  logic                   s1_adv;
  logic                   s2_adv;

  // Stall chain: a stage may load when it is empty or its successor drains.
  assign s2_adv   = !out_valid_reg || out_ready;
  assign s1_adv   = !s1_valid_reg || s2_adv;
  assign in_ready = s1_adv;

  assign op_e  = exp_op_e'(op);
  assign a_ext = {{INT_GUARD{1'b0}}, a};
  assign b_ext = {{INT_GUARD{1'b0}}, b};

  always_comb begin
    s1_term_next = a_ext + b_ext;
    if (op_e == OP_DIV) begin
      s1_term_next = a_ext - b_ext;
    end
  end

  always_comb begin
    r_next = s1_term_reg - BIAS_S;
    if (s1_op_reg == OP_DIV) begin
      r_next = s1_term_reg + BIAS_S;
    end
  end

  exp_classify #(
    .EXP_W (EXP_W)
  ) u_classify (
    .r   (r_next),
    .sat (SAT),
    .exp (cls_exp),
    .ovf (cls_ovf),
    .unf (cls_unf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
    end else if (s1_adv) begin
      s1_valid_reg <= in_valid;
    end
  end

  // Stage-1 payload is only meaningful under s1_valid_reg, so it carries no reset.
  always_ff @(posedge clk) begin
    if (s1_adv && in_valid) begin
      s1_term_reg <= s1_term_next;
      s1_op_reg   <= op_e;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_exp_reg   <= '0;
      out_ovf_reg   <= 1'b0;
      out_unf_reg   <= 1'b0;
    end else if (s2_adv) begin
      out_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        out_exp_reg <= cls_exp;
        out_ovf_reg <= cls_ovf;
        out_unf_reg <= cls_unf;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_exp   = out_exp_reg;
  assign out_ovf   = out_ovf_reg;
  assign out_unf   = out_unf_reg;

endmodule

// File: tb/tb_exp_pipe_unit.sv
// Self-checking bench for exp_pipe_unit: a saturating and a wrapping instance
// share stimulus; a scoreboard queue holds expected results in issue order.
module tb_exp_pipe_unit;
  import exp_pkg::*;

  typedef struct {
    logic [7:0] e_sat;
    logic [7:0] e_wrap;
    logic       ovf;
    logic       unf;
  } res_t;

  typedef struct {
    logic       op;
    logic [7:0] a;
    logic [7:0] b;
    res_t       res;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic       op = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       out_ready = 1'b0;

  logic       in_ready, out_valid, out_ovf, out_unf;
  logic [7:0] out_exp;
  logic       in_ready_ns, out_valid_ns, out_ovf_ns, out_unf_ns;
  logic [7:0] out_exp_ns;

  int checks = 0;
  int errors = 0;
  int pops = 0;

  res_t sb[$];
  res_t pending;
  res_t exp_r;
  vec_t tbl[12];
  vec_t bp[5];

  logic       hold = 1'b0;
  logic [7:0] held_exp, held_exp_ns;
  logic       held_ovf, held_unf;

  always #5 clk = ~clk;

  exp_pipe_unit #(.EXP_W(8), .SAT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .out_exp(out_exp), .out_ovf(out_ovf), .out_unf(out_unf)
  );

  exp_pipe_unit #(.EXP_W(8), .SAT(1'b0)) dut_ns (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_ns),
    .op(op), .a(a), .b(b), .out_valid(out_valid_ns), .out_ready(out_ready),
    .out_exp(out_exp_ns), .out_ovf(out_ovf_ns), .out_unf(out_unf_ns)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  function automatic res_t model(input logic op_i, input logic [7:0] a_i, input logic [7:0] b_i);
    res_t m;
    int   r;
    r = op_i ? (int'(a_i) - int'(b_i) + 127) : (int'(a_i) + int'(b_i) - 127);
    m.ovf    = (r >= 255);
    m.unf    = (r <= 0);
    m.e_wrap = r[7:0];
    m.e_sat  = m.ovf ? 8'd254 : (m.unf ? 8'd0 : r[7:0]);
    return m;
  endfunction

  function automatic vec_t mk(input logic o, input int x, input int y, input int es,
                              input int ew, input logic ov, input logic un);
    vec_t v;
    v.op = o;
    v.a = 8'(x);
    v.b = 8'(y);
    v.res.e_sat = 8'(es);
    v.res.e_wrap = 8'(ew);
    v.res.ovf = ov;
    v.res.unf = un;
    return v;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic o, input logic [7:0] x, input logic [7:0] y, input res_t e);
    op = o;
    a = x;
    b = y;
    pending = e;
    in_valid = 1'b1;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 40 && sb.size() != 0; k++) @(negedge clk);
    @(negedge clk);
    chk(name, sb.size(), 0);
  endtask

  // Monitor: hold stability, pop-and-compare on output transfer, push on input transfer.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_exp", out_exp, held_exp);
        chk("hold_exp_wrap", out_exp_ns, held_exp_ns);
        chk("hold_flags", {out_ovf, out_unf}, {held_ovf, held_unf});
      end
      hold = out_valid && !out_ready;
      held_exp = out_exp;
      held_exp_ns = out_exp_ns;
      held_ovf = out_ovf;
      held_unf = out_unf;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got exp %0d with empty queue at %0t", out_exp, $time);
        end else begin
          exp_r = sb.pop_front();
          pops++;
          $display("out #%0d exp=%0d ovf=%0d unf=%0d wrap_exp=%0d", pops, out_exp, out_ovf, out_unf, out_exp_ns);
          chk("out_exp_sat", out_exp, exp_r.e_sat);
          chk("out_ovf", out_ovf, exp_r.ovf);
          chk("out_unf", out_unf, exp_r.unf);
          chk("wrap_valid", out_valid_ns, 1);
          chk("out_exp_wrap", out_exp_ns, exp_r.e_wrap);
          chk("wrap_ovf", out_ovf_ns, exp_r.ovf);
          chk("wrap_unf", out_unf_ns, exp_r.unf);
        end
      end
      if (in_valid && in_ready) sb.push_back(pending);
    end
  end

  initial begin
    #300000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] ra, rb;
    logic       rop;
    int         idx;
    int         p0;

    tbl[0]  = mk(OP_MUL, 130, 130, 133, 133, 0, 0);
    tbl[1]  = mk(OP_MUL, 254, 254, 254, 125, 1, 0);
    tbl[2]  = mk(OP_MUL, 1,   1,   0,   131, 0, 1);
    tbl[3]  = mk(OP_DIV, 10,  200, 0,   193, 0, 1);
    tbl[4]  = mk(OP_DIV, 127, 127, 127, 127, 0, 0);
    tbl[5]  = mk(OP_DIV, 127, 0,   254, 254, 0, 0);
    tbl[6]  = mk(OP_MUL, 191, 191, 254, 255, 1, 0);
    tbl[7]  = mk(OP_MUL, 64,  63,  0,   0,   0, 1);
    tbl[8]  = mk(OP_MUL, 64,  64,  1,   1,   0, 0);
    tbl[9]  = mk(OP_DIV, 255, 0,   254, 126, 1, 0);
    tbl[10] = mk(OP_DIV, 0,   255, 0,   128, 0, 1);
    tbl[11] = mk(OP_MUL, 0,   0,   0,   129, 0, 1);

    // Asynchronous reset assertion before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_exp", out_exp, 0);
    chk("rst_flags", {out_ovf, out_unf}, 0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Table vectors streamed back to back.
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cyc();
      drive(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res);
      @(negedge clk);
      chk("tbl_in_ready", in_ready, 1);
    end
    cyc();
    in_valid = 1'b0;
    drain("tbl_drain");

    // Two-cycle latency on an idle pipeline.
    cyc();
    drive(OP_MUL, 8'd130, 8'd130, model(OP_MUL, 8'd130, 8'd130));
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_cycle1_valid", out_valid, 0);
    @(negedge clk);
    chk("lat_cycle2_valid", out_valid, 1);
    drain("lat_drain");

    // Backpressure: five operands, downstream stalled for cycles 0-3.
    for (int i = 0; i < 5; i++) begin
      bp[i].op = 1'(i % 2);
      bp[i].a = 8'(100 + 20 * i);
      bp[i].b = 8'(90 - 7 * i);
      bp[i].res = model(bp[i].op, bp[i].a, bp[i].b);
    end
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      cyc();
      drive(bp[idx].op, bp[idx].a, bp[idx].b, bp[idx].res);
      @(negedge clk);
      if (in_ready) idx++;
    end
    chk("bp_accepts_while_stalled", idx, 2);
    chk("bp_in_ready_low", in_ready, 0);
    cyc();
    out_ready = 1'b1;
    p0 = pops;
    for (int c = 0; c < 8 && idx < 5; c++) begin
      if (c > 0) cyc();
      drive(bp[idx].op, bp[idx].a, bp[idx].b, bp[idx].res);
      @(negedge clk);
      if (in_ready) idx++;
    end
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    cyc();
    @(negedge clk);
    cyc();
    chk("bp_results_in_5_cycles", pops - p0, 5);
    @(negedge clk);
    chk("bp_idle_after", out_valid, 0);
    drain("bp_drain");

    // Random traffic with random backpressure.
    for (int c = 0; c < 60; c++) begin
      cyc();
      out_ready = 1'($urandom_range(0, 1));
      rop = 1'($urandom_range(0, 1));
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      drive(rop, ra, rb, model(rop, ra, rb));
      in_valid = ($urandom_range(0, 3) != 0);
    end
    cyc();
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain("rand_drain");

    // Reset with two entries in flight, then recovery.
    cyc();
    out_ready = 1'b0;
    drive(OP_MUL, 8'd200, 8'd100, model(OP_MUL, 8'd200, 8'd100));
    @(negedge clk);
    cyc();
    drive(OP_DIV, 8'd50, 8'd20, model(OP_DIV, 8'd50, 8'd20));
    @(negedge clk);
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid_pipe_full_valid", out_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_exp", out_exp, 0);
    chk("mid_rst_flags", {out_ovf, out_unf}, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_wrap_exp", out_exp_ns, 0);
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    drive(OP_DIV, 8'd127, 8'd0, tbl[5].res);
    out_ready = 1'b1;
    #1 rst_n = 1'b1;
    sb.push_back(pending);
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_lat_cycle1", out_valid, 0);
    @(negedge clk);
    chk("post_rst_lat_cycle2", out_valid, 1);
    drain("post_rst_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exp_pipe_unit.md
# exp_pipe_unit

Pipelined, parametrised exponent unit for the fused floating-point datapath. It computes the biased result exponent of a multiply (ea + eb − BIAS) or a divide (ea − eb + BIAS) and flags overflow and underflow. It optionally saturates the result. It sits between operand unpacking and the mantissa normaliser, and it throttles the upstream stage through a valid/ready handshake.

## Interface
- EXP_W, 8, exponent field width (≥ 3)
- BIAS, 2**(EXP_W-1)-1, exponent bias
- SAT, 1, 1: clamp out-of-range results; 0: emit low EXP_W bits of the wrapped result
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- in_valid  in  1  operand pair valid
- in_ready  out  1  unit can accept operands this cycle
- op  in  1  0 = OP_MUL, 1 = OP_DIV
- a  in  EXP_W  biased exponent of operand A (unsigned)
- b  in  EXP_W  biased exponent of operand B (unsigned)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_exp  out  EXP_W  result biased exponent
- out_ovf  out  1  result ≥ 2**EXP_W − 1 (reserved all-ones code)
- out_unf  out  1  result ≤ 0

## Operation
- Arithmetic is done in signed EXP_W+2 bits. Both operands are zero-extended; no intermediate wraps.
- Stage 1 registers the raw term: a+b for OP_MUL, a−b for OP_DIV. It also registers op.
- Stage 2 applies the bias, −BIAS for OP_MUL and +BIAS for OP_DIV, then classifies the result r:
  - r ≥ 2**EXP_W − 1 → out_ovf=1. With SAT=1, out_exp = 2**EXP_W − 2 (max finite).
  - r ≤ 0 → out_unf=1. With SAT=1, out_exp = 0.
  - Otherwise out_exp = r[EXP_W-1:0] and both flags are 0.
  - With SAT=0, out_exp = r[EXP_W-1:0] in all cases; the flags are still set.
- out_ovf and out_unf are never both 1.
- Operand special cases (zero, inf, NaN) are outside this block's scope; codes are treated arithmetically.

## Timing
- Latency: 2 cycles from an accepted input (in_valid & in_ready) to out_valid, when there is no backpressure.
- Throughput: 1 result per cycle while out_ready=1.
- Handshake:
  - Transfer happens when valid & ready at the clock edge.
  - out_valid, once high, stays high until accepted.
  - out_exp, out_ovf and out_unf are stable while out_valid=1 and out_ready=0.
  - in_ready must not depend combinationally on in_valid.
- Stall logic:
  - s2_adv = !out_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv.
  - A full pipeline with out_ready=0 holds exactly 2 entries, and in_ready=0.
- Simultaneous accept-in and accept-out with both stages full: every stage advances in the same edge; nothing is lost or duplicated.
- Reset:
  - rst_n low immediately clears s1_valid and out_valid, and drives out_exp, out_ovf and out_unf to 0.
  - in_ready reads 1 while in reset.
  - In-flight operations are discarded.
  - Data registers other than the outputs need no reset.
- First accept is allowed on the first rising edge after rst_n deasserts.

## Structure
- Package exp_pkg holds:
  - the op encoding OP_MUL/OP_DIV as a 1-bit enum typedef;
  - a function default_bias(w) returning 2**(w-1)−1;
  - a localparam for the internal width, EXP_W+2.
- Sub-module exp_classify is purely combinational:
  - inputs: signed r and SAT;
  - outputs: exp, ovf, unf.
  - It is instantiated in stage 2.
- Everything else (stage registers, handshake) lives in exp_pipe_unit.

## Test plan
- EXP_W=8, SAT=1, OP_MUL, a=130, b=130 → two cycles later out_exp=133, ovf=0, unf=0.
- OP_MUL, a=254, b=254 (r=381) → out_exp=254, out_ovf=1. With SAT=0, out_exp=125 (381 mod 256) and out_ovf=1.
- OP_MUL, a=1, b=1 (r=−125) → out_exp=0, out_unf=1. Also OP_DIV, a=10, b=200 (r=−63) → out_exp=0, out_unf=1.
- OP_DIV, a=127, b=127 → out_exp=127. OP_DIV, a=127, b=0 → out_exp=254, no flags (boundary, just below ovf).
- Backpressure:
  - Stimulus: in_valid=1 for 5 back-to-back operands, with out_ready=0 for cycles 0–3.
  - in_ready falls after 2 accepts.
  - After out_ready=1, all 5 results emerge in order, one per cycle, with none dropped or repeated.
- Reset mid-stream: assert rst_n=0 asynchronously with 2 entries in flight → out_valid=0 and outputs=0 immediately. After release, the next operand produces a correct result with 2-cycle latency.
